audio_i2s_ctrl: RTL and testbench



---
 rtl/audio_i2s_pkg.sv | 18 +
 rtl/audio_sync_edge.sv | 33 +++
 rtl/audio_i2s_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_audio_i2s_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_i2s_pkg.sv
// Shared types for the codec-side I2S controller: FSM states, channel
// encoding and the default sample width.
package audio_i2s_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_t;

endpackage

// File: rtl/audio_sync_edge.sv
// Two-flop synchronizer with a third aligned stage; level, rise and fall
// outputs all change in the same cycle, 3 clk after the pin edge.
module audio_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] sync_p0;
  logic [W-1:0] sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      level   <= '0;
      rise    <= '0;
      fall    <= '0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      level   <= sync_p1;
      rise    <= sync_p1 & ~level;
      fall    <= ~sync_p1 & level;
    end
  end

endmodule

// File: rtl/audio_i2s_ctrl.sv
// I2S slave for a WM8731-style codec: captures ADC stereo pairs into a
// valid/ready stream and plays DAC pairs from a one-entry holding register.
module audio_i2s_ctrl
  import audio_i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                enable,
  input  logic                audio_BCLK,
  input  logic                audio_ADCLRCK,
  input  logic                audio_ADCDAT,
  input  logic                audio_DACLRCK,
  output logic                audio_DACDAT,
  output logic                adc_valid,
  input  logic                adc_ready,
  output logic [SAMPLE_W-1:0] adc_left,
  output logic [SAMPLE_W-1:0] adc_right,
  output logic                adc_overrun,
  input  logic                dac_valid,
  output logic                dac_ready,
  input  logic [SAMPLE_W-1:0] dac_left,
  input  logic [SAMPLE_W-1:0] dac_right,
  output logic                dac_underrun
);

  localparam int CNT_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

  logic       bclk_unused_lvl, bclk_rise, bclk_fall;
  logic [2:0] pins_lvl, pins_unused_rise, pins_unused_fall;
  logic       adclrck_s, adcdat_s, daclrck_s;

  audio_sync_edge #(.W(1)) u_bclk_sync (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .din   (audio_BCLK),
    .level (bclk_unused_lvl),
    .rise  (bclk_rise),
    .fall  (bclk_fall)
  );

  audio_sync_edge #(.W(3)) u_pin_sync (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .din   ({audio_ADCLRCK, audio_ADCDAT, audio_DACLRCK}),
    .level (pins_lvl),
    .rise  (pins_unused_rise),
    .fall  (pins_unused_fall)
  );

  assign adclrck_s = pins_lvl[2];
  assign adcdat_s  = pins_lvl[1];
  assign daclrck_s = pins_lvl[0];

  // ---- capture: synchronized pins -> shift register -> output pair
  state_t              cap_state;
  chan_t               cap_chan;
  logic [CNT_W-1:0]    cap_cnt;
  logic                adc_lrck_q, left_ok;
  logic [SAMPLE_W-1:0] cap_sr, left_stage, cap_word;
  logic                adc_lrck_chg, cap_last, pair_done;

  assign adc_lrck_chg = bclk_rise && (adclrck_s != adc_lrck_q);
  assign cap_word     = {cap_sr[SAMPLE_W-2:0], adcdat_s};
  assign cap_last     = enable && bclk_rise && !adc_lrck_chg &&
                        (cap_state == SHIFT) && (cap_cnt == LAST_BIT);
  // A right word only forms a pair if a complete left word preceded it.
  assign pair_done    = cap_last && (cap_chan == RIGHT) && left_ok;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cap_state  <= IDLE;
      cap_chan   <= LEFT;
      cap_cnt    <= '0;
      adc_lrck_q <= 1'b0;
      left_ok    <= 1'b0;
    end else begin
      if (bclk_rise) adc_lrck_q <= adclrck_s;
      if (!enable) begin
        cap_state <= IDLE;
        left_ok   <= 1'b0;
      end else if (adc_lrck_chg) begin
        cap_state <= SHIFT;
        cap_chan  <= chan_t'(adclrck_s);
        cap_cnt   <= '0;
        if (!adclrck_s) left_ok <= 1'b0;
      end else if (bclk_rise && cap_state == SHIFT) begin
        cap_cnt <= cap_cnt + 1'b1;
        if (cap_cnt == LAST_BIT) begin
          cap_state <= DONE;
          left_ok   <= (cap_chan == LEFT);
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (bclk_rise && cap_state == SHIFT) cap_sr <= cap_word;
    if (cap_last && cap_chan == LEFT) left_stage <= cap_word;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      adc_valid   <= 1'b0;
      adc_left    <= '0;
      adc_right   <= '0;
      adc_overrun <= 1'b0;
    end else begin
      adc_overrun <= 1'b0;
      if (!enable) begin
        adc_valid <= 1'b0;
      end else if (pair_done) begin
        adc_valid   <= 1'b1;
        adc_left    <= left_stage;
        adc_right   <= cap_word;
        adc_overrun <= adc_valid && !adc_ready;
      end else if (adc_ready) begin
        adc_valid <= 1'b0;
      end
    end
  end

  // ---- playback: holding register -> play latch -> serializer
  state_t              play_state;
  logic [CNT_W-1:0]    play_cnt;
  logic                dac_lrck_q, hold_full;
  logic [SAMPLE_W-1:0] hold_left, hold_right, play_right, play_sr;
  logic                dac_lrck_chg, left_start, dac_load;

  assign dac_lrck_chg = bclk_fall && (daclrck_s != dac_lrck_q);
  assign left_start   = enable && dac_lrck_chg && !daclrck_s;
  assign dac_ready    = enable && !hold_full;
  assign dac_load     = dac_valid && dac_ready;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      play_state   <= IDLE;
      play_cnt     <= '0;
      dac_lrck_q   <= 1'b0;
      hold_full    <= 1'b0;
      play_right   <= '0;
      audio_DACDAT <= 1'b0;
      dac_underrun <= 1'b0;
    end else begin
      dac_underrun <= 1'b0;
      if (bclk_fall) dac_lrck_q <= daclrck_s;
      if (!enable) begin
        play_state   <= IDLE;
        hold_full    <= 1'b0;
        play_right   <= '0;
        audio_DACDAT <= 1'b0;
      end else begin
        if (dac_load) hold_full <= 1'b1;
        else if (left_start) hold_full <= 1'b0;
        if (left_start) begin
          play_right   <= hold_full ? hold_right : '0;
          dac_underrun <= !hold_full;
        end
        if (dac_lrck_chg) begin
          play_state   <= SHIFT;
          play_cnt     <= '0;
          audio_DACDAT <= 1'b0;
        end else if (bclk_fall) begin
          if (play_state == SHIFT) begin
            audio_DACDAT <= play_sr[SAMPLE_W-1];
            play_cnt     <= play_cnt + 1'b1;
            if (play_cnt == LAST_BIT) play_state <= DONE;
          end else begin
            audio_DACDAT <= 1'b0;
          end
        end
      end
    end
  end

  // Left word comes straight from the holding register at the left start.
  always_ff @(posedge clk_clk) begin
    if (dac_load) begin
      hold_left  <= dac_left;
      hold_right <= dac_right;
    end
    if (dac_lrck_chg)
      play_sr <= daclrck_s ? play_right : (hold_full ? hold_left : '0);
    else if (bclk_fall && play_state == SHIFT)
      play_sr <= play_sr << 1;
  end

endmodule

// File: tb/tb_audio_i2s_ctrl.sv
// Bench for audio_i2s_ctrl: the bench plays the codec (BCLK master) and
// compares captured pairs and the DACDAT bitstream against frame-level expectations.
`timescale 1ns/1ps
module tb_audio_i2s_ctrl;

  localparam int SW      = 16;
  localparam int HALF_NS = 163;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n, enable;
  logic          audio_BCLK, audio_ADCLRCK, audio_ADCDAT, audio_DACLRCK, audio_DACDAT;
  logic          adc_valid, adc_ready, adc_overrun;
  logic          dac_valid, dac_ready, dac_underrun;
  logic [SW-1:0] adc_left, adc_right, dac_left, dac_right;

  int tests = 0;
  int fails = 0;

  logic [2*SW-1:0] got_q[$];
  int   valid_cyc = 0, ovr_cyc = 0, ovr_pulses = 0, und_cyc = 0;
  logic ovr_prev = 1'b0;

  logic [31:0] bl, br;
  int          n0, v0, u0, o0, p0;

  typedef struct {
    logic [SW-1:0] l, r, dl, dr;
    logic          load;
    logic [31:0]   exp_bl, exp_br;
    logic          exp_und;
  } vec_t;

  vec_t vecs[8];

  always #10 clk_clk = ~clk_clk;

  audio_i2s_ctrl #(.SAMPLE_W(SW)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .enable        (enable),
    .audio_BCLK    (audio_BCLK),
    .audio_ADCLRCK (audio_ADCLRCK),
    .audio_ADCDAT  (audio_ADCDAT),
    .audio_DACLRCK (audio_DACLRCK),
    .audio_DACDAT  (audio_DACDAT),
    .adc_valid     (adc_valid),
    .adc_ready     (adc_ready),
    .adc_left      (adc_left),
    .adc_right     (adc_right),
    .adc_overrun   (adc_overrun),
    .dac_valid     (dac_valid),
    .dac_ready     (dac_ready),
    .dac_left      (dac_left),
    .dac_right     (dac_right),
    .dac_underrun  (dac_underrun)
  );

  always @(negedge clk_clk) begin
    if (adc_valid && adc_ready) got_q.push_back({adc_left, adc_right});
    if (adc_valid) valid_cyc++;
    if (adc_overrun) ovr_cyc++;
    if (adc_overrun && !ovr_prev) ovr_pulses++;
    ovr_prev = adc_overrun;
    if (dac_underrun) und_cyc++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // One 32-bit I2S slot as the codec sees it: delay bit, word MSB first, zero pad.
  function automatic logic [31:0] slot_bits(input logic [SW-1:0] w);
    return {1'b0, w, 15'b0};
  endfunction

  function automatic vec_t mk(input logic [SW-1:0] l, input logic [SW-1:0] r,
                              input logic [SW-1:0] dl, input logic [SW-1:0] dr,
                              input logic load);
    vec_t v;
    v.l = l; v.r = r; v.dl = dl; v.dr = dr; v.load = load;
    v.exp_bl  = slot_bits(load ? dl : '0);
    v.exp_br  = slot_bits(load ? dr : '0);
    v.exp_und = !load;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #2;
  endtask

  task automatic idle_bits(input int n);
    for (int b = 0; b < n; b++) begin
      audio_BCLK    = 1'b0;
      audio_ADCLRCK = 1'b1;
      audio_DACLRCK = 1'b1;
      audio_ADCDAT  = 1'($urandom);
      #(HALF_NS);
      audio_BCLK = 1'b1;
      #(HALF_NS);
    end
  endtask

  // Codec side of one frame; the left slot can be cut short and a reset
  // can be pulsed at a given bit of the right slot.
  task automatic codec_frame(input logic [SW-1:0] l, input logic [SW-1:0] r,
                             input int left_len, input int rst_bit,
                             output logic [31:0] fl, output logic [31:0] fr);
    logic [SW-1:0] w;
    int nbits;
    fl = '0;
    fr = '0;
    for (int s = 0; s < 2; s++) begin
      w     = (s == 0) ? l : r;
      nbits = (s == 0) ? left_len : 32;
      for (int b = 0; b < nbits; b++) begin
        audio_BCLK    = 1'b0;
        audio_ADCLRCK = (s == 1);
        audio_DACLRCK = (s == 1);
        audio_ADCDAT  = (b >= 1 && b <= SW) ? w[SW - b] : 1'($urandom);
        if (s == 1 && b == rst_bit) begin
          reset_reset_n = 1'b0;
          #60;
          chk1("rst_adc_valid", adc_valid, 1'b0);
          chk("rst_adc_pair", {adc_left, adc_right}, 32'h0);
          chk1("rst_dacdat", audio_DACDAT, 1'b0);
          chk1("rst_overrun", adc_overrun, 1'b0);
          chk1("rst_underrun", dac_underrun, 1'b0);
          reset_reset_n = 1'b1;
        end
        #(HALF_NS);
        audio_BCLK = 1'b1;
        if (s == 0) fl[31 - b] = audio_DACDAT;
        else        fr[31 - b] = audio_DACDAT;
        #(HALF_NS);
      end
    end
  endtask

  task automatic dac_load(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int n;
    n = 0;
    tick();
    dac_valid = 1'b1;
    dac_left  = l;
    dac_right = r;
    while (!dac_ready && n < 50) begin
      tick();
      n++;
    end
    chk1("dac_load_accepted", dac_ready, 1'b1);
    tick();
    dac_valid = 1'b0;
    chk1("dac_ready_after_load", dac_ready, 1'b0);
  endtask

  initial begin
    reset_reset_n = 1'b0;
    enable        = 1'b0;
    audio_BCLK    = 1'b1;
    audio_ADCLRCK = 1'b1;
    audio_DACLRCK = 1'b1;
    audio_ADCDAT  = 1'b0;
    adc_ready     = 1'b1;
    dac_valid     = 1'b0;
    dac_left      = '0;
    dac_right     = '0;
    repeat (5) @(posedge clk_clk);
    @(negedge clk_clk);
    chk1("reset_adc_valid", adc_valid, 1'b0);
    chk("reset_adc_pair", {adc_left, adc_right}, 32'h0);
    chk1("reset_overrun", adc_overrun, 1'b0);
    chk1("reset_underrun", dac_underrun, 1'b0);
    chk1("reset_dacdat", audio_DACDAT, 1'b0);
    chk1("reset_dac_ready", dac_ready, 1'b0);

    tick();
    reset_reset_n = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    chk1("enabled_dac_ready", dac_ready, 1'b1);
    idle_bits(4);

    vecs[0] = mk(16'h1234, 16'hABCD, 16'h8001, 16'h7FFE, 1'b1);
    vecs[1] = mk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    vecs[2] = mk(16'h0001, 16'h8000, 16'hFFFF, 16'h0001, 1'b1);
    vecs[3] = mk(16'h5A5A, 16'hA5A5, 16'h0000, 16'hFFFF, 1'b1);
    for (int i = 4; i < 8; i++)
      vecs[i] = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   1'($urandom));

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].load) dac_load(vecs[i].dl, vecs[i].dr);
      n0 = got_q.size(); v0 = valid_cyc; u0 = und_cyc;
      codec_frame(vecs[i].l, vecs[i].r, 32, -1, bl, br);
      repeat (4) tick();
      chk($sformatf("row%0d_pairs", i), 32'(got_q.size() - n0), 32'd1);
      if (got_q.size() > n0)
        chk($sformatf("row%0d_pair", i), got_q[$], {vecs[i].l, vecs[i].r});
      chk($sformatf("row%0d_valid_cycles", i), 32'(valid_cyc - v0), 32'd1);
      chk($sformatf("row%0d_underruns", i), 32'(und_cyc - u0), 32'(vecs[i].exp_und));
      chk($sformatf("row%0d_dac_left_slot", i), bl, vecs[i].exp_bl);
      chk($sformatf("row%0d_dac_right_slot", i), br, vecs[i].exp_br);
    end

    // Consumer stalls across two frames.
    tick();
    adc_ready = 1'b0;
    n0 = got_q.size(); o0 = ovr_cyc; p0 = ovr_pulses; u0 = und_cyc;
    codec_frame(16'h1111, 16'h2222, 32, -1, bl, br);
    codec_frame(16'h3333, 16'h4444, 32, -1, bl, br);
    repeat (4) tick();
    chk("ovr_cycles", 32'(ovr_cyc - o0), 32'd1);
    chk("ovr_pulses", 32'(ovr_pulses - p0), 32'd1);
    chk1("ovr_valid_held", adc_valid, 1'b1);
    chk("ovr_pair_held", {adc_left, adc_right}, 32'h3333_4444);
    chk("ovr_no_transfer", 32'(got_q.size() - n0), 32'd0);
    chk("ovr_underruns", 32'(und_cyc - u0), 32'd2);
    chk1("underrun_dac_ready", dac_ready, 1'b1);
    chk("underrun_left_slot", bl, 32'h0);
    chk("underrun_right_slot", br, 32'h0);
    adc_ready = 1'b1;
    repeat (3) tick();
    chk("ovr_drain_count", 32'(got_q.size() - n0), 32'd1);
    if (got_q.size() > n0) chk("ovr_drain_pair", got_q[$], 32'h3333_4444);
    chk1("ovr_drain_valid", adc_valid, 1'b0);

    // LRCK flips after 8 bits of the left word.
    n0 = got_q.size();
    codec_frame(16'hDEAD, 16'hBEEF, 9, -1, bl, br);
    repeat (4) tick();
    chk("abort_no_pair", 32'(got_q.size() - n0), 32'd0);
    codec_frame(16'hC3C3, 16'h3C3C, 32, -1, bl, br);
    repeat (4) tick();
    chk("abort_next_count", 32'(got_q.size() - n0), 32'd1);
    if (got_q.size() > n0) chk("abort_next_pair", got_q[$], 32'hC3C3_3C3C);

    // Reset pulse in the middle of the right word.
    n0 = got_q.size();
    codec_frame(16'h7777, 16'h8888, 32, 8, bl, br);
    repeat (4) tick();
    chk("rst_no_pair", 32'(got_q.size() - n0), 32'd0);
    chk1("rst_valid_after", adc_valid, 1'b0);
    codec_frame(16'h2468, 16'h1357, 32, -1, bl, br);
    repeat (4) tick();
    chk("rst_next_count", 32'(got_q.size() - n0), 32'd1);
    if (got_q.size() > n0) chk("rst_next_pair", got_q[$], 32'h2468_1357);

    // enable low flushes a loaded pair.
    dac_load(16'hCAFE, 16'hBEEF);
    enable = 1'b0;
    repeat (3) tick();
    chk1("dis_dac_ready", dac_ready, 1'b0);
    chk1("dis_adc_valid", adc_valid, 1'b0);
    chk1("dis_dacdat", audio_DACDAT, 1'b0);
    enable = 1'b1;
    tick();
    chk1("reen_dac_ready", dac_ready, 1'b1);
    n0 = got_q.size(); u0 = und_cyc;
    codec_frame(16'h0F0F, 16'hF0F0, 32, -1, bl, br);
    repeat (4) tick();
    chk("reen_underruns", 32'(und_cyc - u0), 32'd1);
    chk("reen_left_slot", bl, 32'h0);
    chk("reen_right_slot", br, 32'h0);
    chk("reen_count", 32'(got_q.size() - n0), 32'd1);
    if (got_q.size() > n0) chk("reen_pair", got_q[$], 32'h0F0F_F0F0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
